// File: rtl/pu_row.sv
// Transposed-form multiply-accumulate row: a shift-loaded weight chain, a
// broadcast activation and a saturated, registered dot-product output.
module pu_row #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PE     = 4,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  w_load,
    input  logic [DATA_WIDTH-1:0] w_in,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic                  signed_mode,
    input  logic                  clear,
    output logic [ACC_WIDTH-1:0]  P,
    output logic                  out_valid,
    output logic                  sat,
    output logic                  w_ready,
    output logic                  primed
);

    localparam int FW = 2*DATA_WIDTH + $clog2(NUM_PE) + 1;
    localparam int CW = $clog2(NUM_PE + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(NUM_PE);

    typedef logic signed [FW-1:0] full_t;

    localparam full_t ONE  = full_t'(1);
    localparam full_t SMAX = (ONE <<< (ACC_WIDTH-1)) - ONE;
    localparam full_t SMIN = -(ONE <<< (ACC_WIDTH-1));
    localparam full_t UMAX = (ONE <<< ACC_WIDTH) - ONE;

    logic [DATA_WIDTH-1:0] w [NUM_PE];
    full_t                 r [1:NUM_PE-1];
    full_t                 prod [NUM_PE];
    full_t                 x_ext;
    full_t                 y;
    full_t                 y_sat;
    logic                  y_clip;
    logic [CW-1:0]         wcnt;
    logic [CW-1:0]         scnt;
    logic                  accept;

    // Operands widened to full precision so every sum below is exact.
    function automatic full_t ext(input logic [DATA_WIDTH-1:0] v, input logic s);
        return {{(FW-DATA_WIDTH){s & v[DATA_WIDTH-1]}}, v};
    endfunction

    assign accept  = en && in_valid && !w_load && !clear;
    assign w_ready = (wcnt == FULL_CNT);
    assign primed  = (scnt == FULL_CNT);

    always_comb begin
        x_ext = ext(a, signed_mode);
        for (int i = 0; i < NUM_PE; i++) begin
            prod[i] = ext(w[i], signed_mode) * x_ext;
        end
        y      = r[1] + prod[0];
        y_sat  = y;
        y_clip = 1'b0;
        if (signed_mode) begin
            if (y > SMAX) begin
                y_sat  = SMAX;
                y_clip = 1'b1;
            end else if (y < SMIN) begin
                y_sat  = SMIN;
                y_clip = 1'b1;
            end
        end else begin
            if (y > UMAX) begin
                y_sat  = UMAX;
                y_clip = 1'b1;
            end else if (y < '0) begin
                y_sat  = '0;
                y_clip = 1'b1;
            end
        end
    end

    // NOTE: the weight and partial-sum arrays are reset like any other state,
    // because a reset mid-stream must leave the next stream seeing zero history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PE; i++) w[i] <= '0;
            for (int i = 1; i < NUM_PE; i++) r[i] <= '0;
            P         <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            wcnt      <= '0;
            scnt      <= '0;
        end else begin
            // NOTE: non-blocking assignments let every tap read the pre-edge
            // value of its neighbour, which is what makes the chains shift.
            out_valid <= 1'b0;
            if (en && w_load) begin
                w[0] <= w_in;
                for (int i = 1; i < NUM_PE; i++) w[i] <= w[i-1];
                if (wcnt != FULL_CNT) wcnt <= wcnt + 1'b1;
            end
            if (en && clear) begin
                for (int i = 1; i < NUM_PE; i++) r[i] <= '0;
                scnt <= '0;
                sat  <= 1'b0;
            end else if (accept) begin
                r[NUM_PE-1] <= prod[NUM_PE-1];
                for (int i = 1; i < NUM_PE-1; i++) r[i] <= r[i+1] + prod[i];
                P         <= y_sat[ACC_WIDTH-1:0];
                sat       <= y_clip;
                out_valid <= 1'b1;
                if (scnt != FULL_CNT) scnt <= scnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pu_row.sv
// Directed, table-driven bench for pu_row at its default parameters.
module tb_pu_row;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        w_load;
    logic [7:0]  w_in;
    logic        in_valid;
    logic [7:0]  a;
    logic        signed_mode;
    logic        clear;
    logic [15:0] P;
    logic        out_valid;
    logic        sat;
    logic        w_ready;
    logic        primed;

    int n_pass  = 0;
    int n_total = 0;

    pu_row #(.DATA_WIDTH(8), .NUM_PE(4), .ACC_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .en(en), .w_load(w_load), .w_in(w_in),
        .in_valid(in_valid), .a(a), .signed_mode(signed_mode), .clear(clear),
        .P(P), .out_valid(out_valid), .sat(sat), .w_ready(w_ready), .primed(primed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en, wl;
        logic [7:0]  wi;
        logic        iv;
        logic [7:0]  a;
        logic        clr, sm;
        logic        ov;
        logic [15:0] p;
        logic        st, pr, wr;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic en_v, logic wl_v, logic [7:0] wi_v, logic iv_v,
                                logic [7:0] a_v, logic clr_v, logic sm_v, logic ov_v,
                                logic [15:0] p_v, logic st_v, logic pr_v, logic wr_v);
        vec_t v;
        v.en = en_v; v.wl = wl_v; v.wi = wi_v; v.iv = iv_v; v.a = a_v;
        v.clr = clr_v; v.sm = sm_v; v.ov = ov_v; v.p = p_v; v.st = st_v;
        v.pr = pr_v; v.wr = wr_v;
        vq.push_back(v);
    endfunction

    function automatic void ld(logic [7:0] wi_v, logic [15:0] p_v, logic st_v, logic pr_v, logic wr_v);
        add(1, 1, wi_v, 0, 0, 0, 0, 0, p_v, st_v, pr_v, wr_v);
    endfunction

    function automatic void smp(logic [7:0] a_v, logic sm_v, logic [15:0] p_v, logic st_v, logic pr_v);
        add(1, 0, 0, 1, a_v, 0, sm_v, 1, p_v, st_v, pr_v, 1);
    endfunction

    function automatic void idle(logic en_v, logic iv_v, logic [7:0] a_v, logic [15:0] p_v, logic st_v, logic pr_v);
        add(en_v, 0, 0, iv_v, a_v, 0, 0, 0, p_v, st_v, pr_v, 1);
    endfunction

    function automatic void clr(logic [15:0] p_v);
        add(1, 0, 0, 0, 0, 1, 0, 0, p_v, 0, 0, 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic en_v, input logic wl_v, input logic [7:0] wi_v,
                         input logic iv_v, input logic [7:0] a_v, input logic clr_v,
                         input logic sm_v);
        en = en_v; w_load = wl_v; w_in = wi_v; in_valid = iv_v; a = a_v;
        clear = clr_v; signed_mode = sm_v;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Load 4,3,2,1 then stream 1..5.
        ld(4, 0, 0, 0, 0); ld(3, 0, 0, 0, 0); ld(2, 0, 0, 0, 0); ld(1, 0, 0, 0, 1);
        smp(1, 0, 1, 0, 0); smp(2, 0, 4, 0, 0); smp(3, 0, 10, 0, 0);
        smp(4, 0, 20, 0, 1); smp(5, 0, 30, 0, 1);
        idle(1, 0, 0, 30, 0, 1);
        // Same stream with in_valid gaps and en=0 cycles.
        clr(30);
        smp(1, 0, 1, 0, 0); idle(1, 0, 0, 1, 0, 0);
        smp(2, 0, 4, 0, 0); idle(0, 1, 8'd99, 4, 0, 0);
        smp(3, 0, 10, 0, 0); idle(1, 0, 0, 10, 0, 0);
        smp(4, 0, 20, 0, 1); idle(0, 1, 8'd77, 20, 0, 1);
        smp(5, 0, 30, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 30, 0, 1, 1);
        // Clear mid-stream, then a sample colliding with a weight load.
        clr(30);
        smp(1, 0, 1, 0, 0); smp(2, 0, 4, 0, 0); smp(3, 0, 10, 0, 0);
        clr(10);
        smp(5, 0, 5, 0, 0);
        add(1, 1, 9, 1, 7, 0, 0, 0, 5, 0, 0, 1);
        smp(1, 0, 19, 0, 0); smp(0, 0, 16, 0, 0);
        // Signed saturation with all weights 127.
        ld(127, 16, 0, 0, 1); ld(127, 16, 0, 0, 1); ld(127, 16, 0, 0, 1); ld(127, 16, 0, 0, 1);
        clr(16);
        smp(127, 1, 16129, 0, 0); smp(127, 1, 32258, 0, 0);
        smp(127, 1, 32767, 1, 0); smp(127, 1, 32767, 1, 1);
        clr(32767);
        smp(8'h80, 1, 16'hC080, 0, 0); smp(8'h80, 1, 16'h8100, 0, 0);
        smp(8'h80, 1, 16'h8000, 1, 0); smp(8'h80, 1, 16'h8000, 1, 1);
        clr(16'h8000);
        smp(1, 1, 127, 0, 0); smp(1, 1, 254, 0, 0); smp(1, 1, 381, 0, 0); smp(1, 1, 508, 0, 1);
        // Unsigned saturation with all weights 255.
        ld(255, 508, 0, 1, 1); ld(255, 508, 0, 1, 1); ld(255, 508, 0, 1, 1); ld(255, 508, 0, 1, 1);
        clr(508);
        smp(255, 0, 16'hFE01, 0, 0); smp(255, 0, 16'hFFFF, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_P", {16'b0, P}, 32'd0);
        check("reset_flags", {28'b0, out_valid, sat, w_ready, primed}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].en, vq[i].wl, vq[i].wi, vq[i].iv, vq[i].a, vq[i].clr, vq[i].sm);
            @(posedge clk);
            #1;
            check($sformatf("row%0d_P", i), {16'b0, P}, {16'b0, vq[i].p});
            check($sformatf("row%0d_ov_sat_pr_wr", i),
                  {28'b0, out_valid, sat, primed, w_ready},
                  {28'b0, vq[i].ov, vq[i].st, vq[i].pr, vq[i].wr});
        end

        // Asynchronous reset in the middle of a streaming cycle.
        @(negedge clk);
        drive(1, 0, 0, 1, 8'd3, 0, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset_P", {16'b0, P}, 32'd0);
        check("async_reset_flags", {28'b0, out_valid, sat, w_ready, primed}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 0, 0, 1, 8'd5, 0, 0);
        @(posedge clk);
        #1;
        check("post_reset_zero_weights", {15'b0, out_valid, P}, {15'b0, 1'b1, 16'd0});
        check("post_reset_wready", {31'b0, w_ready}, 32'd0);

        // Reset in the middle of a weight load restarts the load count.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 1, 8'd1, 0, 0, 0, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 1, 8'd1, 0, 0, 0, 0);
        end
        @(posedge clk);
        #1;
        check("midload_reset_wready_low", {31'b0, w_ready}, 32'd0);
        @(negedge clk);
        drive(1, 1, 8'd1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("midload_reset_wready_high", {31'b0, w_ready}, 32'd1);
        @(negedge clk);
        drive(1, 0, 0, 1, 8'd2, 0, 0);
        @(posedge clk);
        #1;
        check("midload_reset_stream", {15'b0, out_valid, P}, {15'b0, 1'b1, 16'd2});

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
